div_restoring_param: RTL and testbench



---
 rtl/div_restoring_param.sv | 212 +++++++++++++++++++++
 tb/tb_div_restoring_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_restoring_param.sv
// -----------------------------------------------------------------------------
// div_restoring_param
//
// Shared multi-cycle restoring divider with a start/busy/done handshake.
// Operand width is set by WIDTH. Each operation can be signed (two's
// complement) or unsigned. Signed division truncates toward zero, so the
// remainder takes the sign of the dividend. One quotient bit is produced per
// clock, and a single fix-up cycle applies the signs and detects exceptions.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   start        operation request; only looked at while busy=0
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   dividend     dividend, captured when start is accepted
//   divisor      divisor, captured when start is accepted
//   busy         high while an operation is in progress
//   done         one-cycle pulse; results and flags are valid
//   quotient     quotient, held until the next result is written
//   remainder    remainder, held until the next result is written
//   div_by_zero  divisor was zero (quotient all ones, remainder = dividend)
//   overflow     signed most-negative / -1 (quotient wraps to most-negative)
//
// Latency: WIDTH+2 cycles from the cycle start is presented to the done
// cycle, or 2 cycles for a zero divisor. A start presented while done is
// high is accepted, so operations can run back-to-back.
// -----------------------------------------------------------------------------
module div_restoring_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Absolute value of an operand. The most-negative value negates to itself,
  // and that bit pattern read as unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] val,
                                                 input logic                     is_signed);
    magnitude = (is_signed && val[WIDTH-1]) ? -val : val;
  endfunction

  // Re-apply a sign to an unsigned magnitude (two's-complement negate).
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    apply_sign = neg ? -mag : mag;
  endfunction

  // Architectural state
  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  // The partial remainder A is always below M between iterations, so it is
  // held in WIDTH bits. Only the shifted value and the trial subtraction need
  // the extra bit.
  logic [WIDTH-1:0]          a, a_n;
  logic [WIDTH-1:0]          q, q_n;
  logic [WIDTH-1:0]          m, m_n;
  logic                      sign_q, sign_q_n;
  logic                      sign_r, sign_r_n;
  logic                      mode_r, mode_n;
  logic signed [WIDTH-1:0]   dvd_r, dvd_n;
  logic signed [WIDTH-1:0]   dvs_r, dvs_n;
  logic                      busy_n, done_n, dbz_n, ovf_n;
  logic [WIDTH-1:0]          quot_n, rem_n;

  // Iteration datapath
  logic [WIDTH:0]            a_sh;
  logic [WIDTH:0]            trial;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    a_n      = a;
    q_n      = q;
    m_n      = m;
    sign_q_n = sign_q;
    sign_r_n = sign_r;
    mode_n   = mode_r;
    dvd_n    = dvd_r;
    dvs_n    = dvs_r;
    busy_n   = busy;
    done_n   = 1'b0;
    quot_n   = quotient;
    rem_n    = remainder;
    dbz_n    = div_by_zero;
    ovf_n    = overflow;

    // {A,Q} shifted left by one; the top bit of Q moves into A.
    a_sh  = {a, q[WIDTH-1]};
    trial = a_sh - {1'b0, m};

    unique case (state)
      // ---- IDLE: accept and capture an operation ----
      IDLE: begin
        if (start) begin
          dvd_n    = dividend;
          dvs_n    = divisor;
          mode_n   = signed_mode;
          sign_q_n = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_r_n = signed_mode & dividend[WIDTH-1];
          a_n      = '0;
          q_n      = magnitude(dividend, signed_mode);
          m_n      = magnitude(divisor, signed_mode);
          cnt_n    = CNT_INIT;
          dbz_n    = 1'b0;
          ovf_n    = 1'b0;
          busy_n   = 1'b1;
          // A zero divisor needs no iterations; its result is fixed.
          state_n  = (divisor == '0) ? FIXUP : ITER;
        end
      end

      // ---- ITER: one restoring step per cycle ----
      ITER: begin
        if (trial[WIDTH]) begin
          // Trial went negative: keep the shifted remainder, quotient bit 0.
          a_n = a_sh[WIDTH-1:0];
          q_n = {q[WIDTH-2:0], 1'b0};
        end else begin
          a_n = trial[WIDTH-1:0];
          q_n = {q[WIDTH-2:0], 1'b1};
        end
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = FIXUP;
        end
      end

      // ---- FIXUP: sign correction, exceptions, result hand-off ----
      FIXUP: begin
        if (dvs_r == '0) begin
          quot_n = '1;
          rem_n  = dvd_r;
          dbz_n  = 1'b1;
        end else begin
          quot_n = apply_sign(q, sign_q);
          rem_n  = apply_sign(a, sign_r);
        end
        // The wrapped quotient (most-negative) and zero remainder already
        // come out of the normal path; only the flag is raised here.
        ovf_n   = mode_r & (dvd_r == MOST_NEG) & (dvs_r == '1);
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      mode_r      <= 1'b0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      a           <= a_n;
      q           <= q_n;
      m           <= m_n;
      sign_q      <= sign_q_n;
      sign_r      <= sign_r_n;
      mode_r      <= mode_n;
      dvd_r       <= dvd_n;
      dvs_r       <= dvs_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quot_n;
      remainder   <= rem_n;
      div_by_zero <= dbz_n;
      overflow    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_div_restoring_param.sv
module tb_div_restoring_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        s8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  n8 = '0, d8 = '0;
  logic        b8, dn8, z8, o8;
  logic [7:0]  q8, r8;

  // WIDTH=13 instance
  logic        s13 = 1'b0, sm13 = 1'b0;
  logic [12:0] n13 = '0, d13 = '0;
  logic        b13, dn13, z13, o13;
  logic [12:0] q13, r13;

  div_restoring_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
    .dividend(n8), .divisor(d8), .busy(b8), .done(dn8),
    .quotient(q8), .remainder(r8), .div_by_zero(z8), .overflow(o8)
  );

  div_restoring_param #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(s13), .signed_mode(sm13),
    .dividend(n13), .divisor(d13), .busy(b13), .done(dn13),
    .quotient(q13), .remainder(r13), .div_by_zero(z13), .overflow(o13)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truncating-division reference: quotient toward zero, remainder takes the
  // dividend's sign; zero divisor gives all-ones quotient and dividend back.
  task automatic ref_div(input int w, input logic sm, input logic [31:0] n, input logic [31:0] d,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic ez, output logic eo);
    longint one, mask, ln, ld, lq, lr;
    one  = 1;
    mask = (one << w) - one;
    ln   = longint'(n);
    ld   = longint'(d);
    if (sm && n[w-1]) ln = ln - (one << w);
    if (sm && d[w-1]) ld = ld - (one << w);
    ez = (ld == 0);
    eo = sm && (ln == -(one << (w-1))) && (ld == -one);
    if (ez) begin
      lq = mask;
      lr = ln;
    end else begin
      lq = ln / ld;
      lr = ln % ld;
    end
    eq = 32'(lq & mask);
    er = 32'(lr & mask);
  endtask

  // Drive one operation on the 8-bit unit, starting in the current cycle.
  // lat counts cycles from the start cycle up to the done cycle.
  task automatic op8(input logic sm, input logic [7:0] n, input logic [7:0] d, input bit pulse,
                     output logic [7:0] q, output logic [7:0] r, output logic z, output logic o,
                     output int lat, output int gaps);
    s8 = 1'b1; sm8 = sm; n8 = n; d8 = d;
    tick();
    lat  = 1;
    gaps = 0;
    s8   = 1'b0;
    check("accept_busy8", 32'(b8), 32'(1));
    check("done_deassert8", 32'(dn8), 32'(0));
    while (!dn8 && lat < 40) begin
      if (pulse && (lat == 3 || lat == 5)) begin
        s8 = 1'b1; sm8 = ~sm; n8 = 8'h09; d8 = 8'h03;
      end else begin
        s8 = 1'b0;
      end
      tick();
      lat++;
      if (!dn8 && !b8) gaps++;
      if (dn8 && b8) gaps++;
    end
    s8 = 1'b0;
    q = q8; r = r8; z = z8; o = o8;
  endtask

  task automatic op13(input logic sm, input logic [12:0] n, input logic [12:0] d,
                      output logic [12:0] q, output logic [12:0] r, output logic z, output logic o,
                      output int lat);
    s13 = 1'b1; sm13 = sm; n13 = n; d13 = d;
    tick();
    lat = 1;
    s13 = 1'b0;
    check("accept_busy13", 32'(b13), 32'(1));
    while (!dn13 && lat < 40) begin
      tick();
      lat++;
    end
    q = q13; r = r13; z = z13; o = o13;
  endtask

  task automatic do8(input string tag, input logic sm, input logic [7:0] n, input logic [7:0] d,
                     input bit pulse, input logic [7:0] eq, input logic [7:0] er,
                     input logic ez, input logic eo, input int elat);
    logic [7:0] q, r;
    logic       z, o;
    int         lat, gaps;
    op8(sm, n, d, pulse, q, r, z, o, lat, gaps);
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy"}, 32'(gaps), 32'(0));
    check({tag, ".quotient"}, 32'(q), 32'(eq));
    check({tag, ".remainder"}, 32'(r), 32'(er));
    check({tag, ".div_by_zero"}, 32'(z), 32'(ez));
    check({tag, ".overflow"}, 32'(o), 32'(eo));
  endtask

  task automatic do13(input string tag, input logic sm, input logic [12:0] n, input logic [12:0] d,
                      input logic [12:0] eq, input logic [12:0] er, input logic ez, input logic eo,
                      input int elat);
    logic [12:0] q, r;
    logic        z, o;
    int          lat;
    op13(sm, n, d, q, r, z, o, lat);
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".quotient"}, 32'(q), 32'(eq));
    check({tag, ".remainder"}, 32'(r), 32'(er));
    check({tag, ".div_by_zero"}, 32'(z), 32'(ez));
    check({tag, ".overflow"}, 32'(o), 32'(eo));
  endtask

  task automatic sweep8(input int count);
    logic [7:0]  q, r, n, d;
    logic        z, o, sm;
    logic [31:0] eq, er;
    logic        ez, eo;
    int          lat, gaps;
    for (int i = 0; i < count; i++) begin
      sm = i[0];
      n  = 8'($urandom);
      d  = (i % 7 == 3) ? 8'h00 : 8'($urandom);
      op8(sm, n, d, 1'b0, q, r, z, o, lat, gaps);
      ref_div(8, sm, 32'(n), 32'(d), eq, er, ez, eo);
      check("sweep8.quotient", 32'(q), eq);
      check("sweep8.remainder", 32'(r), er);
      check("sweep8.div_by_zero", 32'(z), 32'(ez));
      check("sweep8.overflow", 32'(o), 32'(eo));
    end
  endtask

  task automatic sweep13(input int count);
    logic [12:0] q, r, n, d;
    logic        z, o, sm;
    logic [31:0] eq, er;
    logic        ez, eo;
    int          lat;
    for (int i = 0; i < count; i++) begin
      sm = i[0];
      n  = 13'($urandom);
      d  = (i % 5 == 2) ? 13'($urandom_range(1, 40)) : 13'($urandom);
      op13(sm, n, d, q, r, z, o, lat);
      ref_div(13, sm, 32'(n), 32'(d), eq, er, ez, eo);
      check("sweep13.quotient", 32'(q), eq);
      check("sweep13.remainder", 32'(r), er);
      check("sweep13.div_by_zero", 32'(z), 32'(ez));
      check("sweep13.overflow", 32'(o), 32'(eo));
    end
  endtask

  initial begin
    int saw_done;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check("rst.busy", 32'(b8), 32'(0));
    check("rst.done", 32'(dn8), 32'(0));
    check("rst.quotient", 32'(q8), 32'(0));
    check("rst.remainder", 32'(r8), 32'(0));
    check("rst.flags", 32'({z8, o8}), 32'(0));
    check("rst.busy13", 32'(b13), 32'(0));
    rst = 1'b0;
    tick();

    // Unsigned 200 / 7, then results must hold while idle
    do8("u200_7", 1'b0, 8'd200, 8'd7, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 10);
    repeat (3) tick();
    check("hold.quotient", 32'(q8), 32'(8'h1C));
    check("hold.remainder", 32'(r8), 32'(8'h04));
    check("hold.done", 32'(dn8), 32'(0));
    check("hold.busy", 32'(b8), 32'(0));

    // Signed cases; the second starts in the done cycle of the first
    do8("s_m100_7", 1'b1, 8'h9C, 8'h07, 1'b0, 8'hF2, 8'hFE, 1'b0, 1'b0, 10);
    do8("s_100_m7", 1'b1, 8'h64, 8'hF9, 1'b0, 8'hF2, 8'h02, 1'b0, 1'b0, 10);

    // Divide by zero in both modes, then a clean divide clears the flag
    do8("u_dbz", 1'b0, 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0, 2);
    do8("s_dbz", 1'b1, 8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0, 2);
    do8("u9_3", 1'b0, 8'h09, 8'h03, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 10);

    // Signed overflow, and the same bits as unsigned
    do8("s_ovf", 1'b1, 8'h80, 8'hFF, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 10);
    do8("u128_255", 1'b0, 8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 10);

    // Start pulses while busy are ignored
    do8("ign_start", 1'b0, 8'd200, 8'd7, 1'b1, 8'h1C, 8'h04, 1'b0, 1'b0, 10);

    // Asynchronous reset mid-iteration
    do8("pre_rst", 1'b0, 8'h09, 8'h03, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 10);
    s8 = 1'b1; sm8 = 1'b0; n8 = 8'd200; d8 = 8'd7;
    tick();
    s8 = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst.busy", 32'(b8), 32'(0));
    check("arst.done", 32'(dn8), 32'(0));
    check("arst.quotient", 32'(q8), 32'(0));
    check("arst.remainder", 32'(r8), 32'(0));
    check("arst.flags", 32'({z8, o8}), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dn8 || b8) saw_done++;
    end
    check("arst.no_done", 32'(saw_done), 32'(0));
    do8("post_rst", 1'b0, 8'd200, 8'd7, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 10);

    // WIDTH=13 directed
    do13("w13_u", 1'b0, 13'h1FFF, 13'd3, 13'hAAA, 13'h001, 1'b0, 1'b0, 15);
    do13("w13_s", 1'b1, 13'h1C18, 13'd33, 13'h1FE2, 13'h1FF6, 1'b0, 1'b0, 15);
    do13("w13_ovf", 1'b1, 13'h1000, 13'h1FFF, 13'h1000, 13'h0000, 1'b0, 1'b1, 15);
    do13("w13_dbz", 1'b1, 13'h1234, 13'h0000, 13'h1FFF, 13'h1234, 1'b1, 1'b0, 2);

    // Pseudo-random sweep against the truncating-division reference
    sweep8(24);
    sweep13(24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
